inst_fetch_unit: RTL and testbench
==================================

INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: fetch address after reset.
REQ-002 SHALL have parameter ADDR_W, default 16: memory byte-address width.
REQ-003 SHALL have port Clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 SHALL have port Reset_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port mem_addr, output, ADDR_W: byte address to a synchronous byte-wide RAM.
REQ-006 SHALL have port mem_re, output, 1: mem_addr is a valid read request this cycle.
REQ-007 SHALL have port mem_dout, input, 8: RAM read data, valid exactly one cycle after its request.
REQ-008 SHALL have port redirect_valid, input, 1: single-cycle jump/branch restart request.
REQ-009 SHALL have port redirect_pc, input, 32: restart address, sampled when redirect_valid=1.
REQ-010 SHALL have port inst_valid, output, 1: inst_data/inst_pc hold a complete instruction.
REQ-011 SHALL have port inst_ready, input, 1: the decode stage accepts the instruction this cycle.
REQ-012 SHALL have port inst_data, output, 64: instruction; byte at inst_pc in [63:56], byte at inst_pc+7 in [7:0].
REQ-013 SHALL have port inst_pc, output, 32: address of the first byte of inst_data.

Function
REQ-014 SHALL keep a 32-bit fetch_pc, an issue counter (0..8) and a receive counter (0..8).
REQ-015 SHALL implement states FETCH (issuing and collecting bytes) and HOLD (instruction presented, waiting for acceptance).
REQ-016 FETCH: while issue count < 8, SHALL drive mem_re=1 and mem_addr=(fetch_pc+issue count)[ADDR_W-1:0] each cycle and increment the issue count.
REQ-017 FETCH: a byte requested in cycle N SHALL be captured from mem_dout at the end of cycle N+1 into byte slot (receive count).
REQ-018 When the 8th byte is captured, SHALL enter HOLD with inst_valid=1 and inst_pc=fetch_pc; first request to inst_valid=1 is 9 cycles.
REQ-019 HOLD: mem_re SHALL be 0; inst_data and inst_pc SHALL stay stable while inst_valid=1 and inst_ready=0.
REQ-020 A transfer occurs when inst_valid=1 and inst_ready=1. The next cycle SHALL have inst_valid=0, fetch_pc=fetch_pc+8, state FETCH, and both counters at 0.
REQ-021 inst_ready while inst_valid=0 SHALL be ignored.
REQ-022 redirect_valid=1 in any state SHALL, next cycle, discard all captured and in-flight bytes, force inst_valid=0, set fetch_pc=redirect_pc, clear both counters and enter FETCH.
REQ-023 A data byte returning in the cycle after a redirect belongs to the discarded stream and SHALL NOT be captured.
REQ-024 Redirect and transfer in the same cycle: the transfer SHALL complete and the redirect SHALL determine the next fetch_pc (redirect_pc, not pc+8).
REQ-025 fetch_pc arithmetic SHALL be modulo 2^32; mem_addr SHALL wrap modulo 2^ADDR_W, including within a single instruction.
REQ-026 No alignment requirement: redirect_pc SHALL be any byte address.

Reset
REQ-027 While Reset_n=0 (asynchronous assertion): state=FETCH, fetch_pc=RESET_PC, counters=0, inst_valid=0, inst_data=0, inst_pc=0, mem_re=0, mem_addr=0.
REQ-028 The first read request SHALL be issued in the first rising edge cycle after Reset_n deasserts, at RESET_PC.
REQ-029 Reset asserted mid-fetch or in HOLD SHALL abandon the instruction; no partial inst_valid after release.

Verification
REQ-030 Reset release, RAM[0..7]=01 00 02 03 00 00 00 05, inst_ready=1 -> cycle 9 inst_valid=1, inst_data=64'h0100020300000005, inst_pc=0; next fetch starts at addr 8.
REQ-031 inst_ready held 0 for 20 cycles after inst_valid -> mem_re=0, outputs stable throughout; ready pulse -> inst_valid=0 next cycle, mem_addr=8.
REQ-032 redirect_valid=1, redirect_pc=0x40 after 4 bytes issued -> no inst_valid for old stream; cycle 9 after restart inst_pc=0x40 with RAM[0x40..0x47].
REQ-033 Redirect and transfer same cycle, redirect_pc=0x100 -> instruction consumed once; next inst_pc=0x100, not pc+8.
REQ-034 redirect_pc=0xFFFC, ADDR_W=16 -> mem_addr sequence FFFC, FFFD, FFFE, FFFF, 0000, 0001, 0002, 0003; inst_pc=0x0000FFFC.
REQ-035 Reset_n pulsed low in HOLD -> inst_valid drops immediately (asynchronous); refetch from RESET_PC after release.

Source files
------------

// File: rtl/inst_fetch_unit_if.sv
// Bundle of the instruction fetch unit's memory, redirect and decode signals.
//   mem_addr/mem_re  : byte read request to a synchronous byte-wide RAM
//   mem_dout         : RAM read data, one cycle after its request
//   redirect_valid/pc: single-cycle restart request and its address
//   inst_valid/ready : instruction handshake towards decode
//   inst_data/inst_pc: 8-byte instruction (first byte in [63:56]) and its address
// master = fetch unit side, slave = memory/decode/redirect environment side.
interface inst_fetch_unit_if #(
    parameter int unsigned ADDR_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic [7:0]        mem_dout;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic [63:0]       inst_data;
    logic [31:0]       inst_pc;

    modport master (
        output mem_addr, mem_re, inst_valid, inst_data, inst_pc,
        input  mem_dout, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  mem_addr, mem_re, inst_valid, inst_data, inst_pc,
        output mem_dout, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: reads 8 consecutive bytes from a synchronous
// byte-wide RAM starting at fetch_pc, assembles them into a 64-bit
// instruction and holds it until decode accepts it. A redirect restarts
// fetching at any byte address and discards everything in flight.
// Ports:
//   Clk     : clock, rising edge
//   Reset_n : asynchronous active-low reset
//   bus     : inst_fetch_unit_if master (memory, redirect, decode handshake)
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned ADDR_W   = 16
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    inst_fetch_unit_if.master    bus
);

    typedef enum logic {
        FETCH,
        HOLD
    } state_t;

    state_t      state_q,      state_d;
    logic [31:0] fetch_pc_q,   fetch_pc_d;
    logic [3:0]  issue_cnt_q,  issue_cnt_d;
    logic [3:0]  recv_cnt_q,   recv_cnt_d;
    logic        rvalid_q,     rvalid_d;
    logic        armed_q,      armed_d;
    logic        inst_valid_q, inst_valid_d;
    logic [63:0] inst_data_q,  inst_data_d;
    logic [31:0] inst_pc_q,    inst_pc_d;

    logic        mem_re;
    logic [31:0] issue_addr;

    // armed_q keeps requests off until the first edge after reset release.
    assign mem_re     = armed_q && (state_q == FETCH) && (issue_cnt_q < 4'd8);
    assign issue_addr = fetch_pc_q + 32'(issue_cnt_q);

    assign bus.mem_re     = mem_re;
    assign bus.mem_addr   = mem_re ? issue_addr[ADDR_W-1:0] : '0;
    assign bus.inst_valid = inst_valid_q;
    assign bus.inst_data  = inst_data_q;
    assign bus.inst_pc    = inst_pc_q;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        issue_cnt_d  = issue_cnt_q;
        recv_cnt_d   = recv_cnt_q;
        armed_d      = 1'b1;
        // mem_dout is valid in the cycle after a request.
        rvalid_d     = mem_re;
        inst_valid_d = inst_valid_q;
        inst_data_d  = inst_data_q;
        inst_pc_d    = inst_pc_q;

        case (state_q)
            FETCH: begin
                if (mem_re) begin
                    issue_cnt_d = issue_cnt_q + 4'd1;
                end
                if (rvalid_q) begin
                    // Shift in: after 8 bytes the first one sits in [63:56].
                    inst_data_d = {inst_data_q[55:0], bus.mem_dout};
                    recv_cnt_d  = recv_cnt_q + 4'd1;
                    if (recv_cnt_q == 4'd7) begin
                        state_d      = HOLD;
                        inst_valid_d = 1'b1;
                        inst_pc_d    = fetch_pc_q;
                    end
                end
            end
            HOLD: begin
                if (bus.inst_ready) begin
                    state_d      = FETCH;
                    inst_valid_d = 1'b0;
                    fetch_pc_d   = fetch_pc_q + 32'd8;
                    issue_cnt_d  = '0;
                    recv_cnt_d   = '0;
                end
            end
            default: state_d = FETCH;
        endcase

        // Redirect wins over everything above except that a same-cycle
        // transfer has already completed; only the next pc differs.
        if (bus.redirect_valid) begin
            state_d      = FETCH;
            inst_valid_d = 1'b0;
            fetch_pc_d   = bus.redirect_pc;
            issue_cnt_d  = '0;
            recv_cnt_d   = '0;
            rvalid_d     = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= FETCH;
            fetch_pc_q   <= RESET_PC;
            issue_cnt_q  <= '0;
            recv_cnt_q   <= '0;
            rvalid_q     <= 1'b0;
            armed_q      <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_data_q  <= '0;
            inst_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            issue_cnt_q  <= issue_cnt_d;
            recv_cnt_q   <= recv_cnt_d;
            rvalid_q     <= rvalid_d;
            armed_q      <= armed_d;
            inst_valid_q <= inst_valid_d;
            inst_data_q  <= inst_data_d;
            inst_pc_q    <= inst_pc_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Testbench for inst_fetch_unit: byte RAM model, timeline reference model
// checked every cycle, directed scenarios with literal expectations, then
// randomized ready/redirect traffic.
module tb_inst_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    logic [7:0] ram [0:65535];

    inst_fetch_unit_if #(.ADDR_W(16)) bus ();

    inst_fetch_unit #(.RESET_PC(RST_PC), .ADDR_W(16)) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Synchronous byte-wide RAM.
    always @(posedge clk) begin
        if (bus.mem_re) bus.mem_dout <= ram[bus.mem_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] exp_inst(input logic [31:0] pc);
        logic [63:0] r;
        logic [31:0] a;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            a = pc + 32'(i);
            r = {r[55:0], ram[a[15:0]]};
        end
        return r;
    endfunction

    // Reference model: m_t is the cycle number since the last restart
    // (1 = first request cycle; 0 = idle cycle right after reset release).
    // Cycles 1..8 issue pc..pc+7, cycle 9 is quiet, cycle >=10 presents.
    int          m_t  = 0;
    logic [31:0] m_pc = RST_PC;

    always @(negedge clk) begin
        logic        exp_re, exp_valid;
        logic [31:0] a;
        if (!rst_n) begin
            chk("rst_mem_re", 64'(bus.mem_re), 64'd0);
            chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
            chk("rst_valid", 64'(bus.inst_valid), 64'd0);
            chk("rst_data", bus.inst_data, 64'd0);
            chk("rst_pc", 64'(bus.inst_pc), 64'd0);
            m_t  = 0;
            m_pc = RST_PC;
        end else begin
            exp_re    = (m_t >= 1) && (m_t <= 8);
            exp_valid = (m_t >= 10);
            chk("mem_re", 64'(bus.mem_re), 64'(exp_re));
            if (exp_re) begin
                a = m_pc + 32'(m_t - 1);
                chk("mem_addr", 64'(bus.mem_addr), 64'(a[15:0]));
            end
            chk("inst_valid", 64'(bus.inst_valid), 64'(exp_valid));
            if (exp_valid) begin
                chk("inst_pc", 64'(bus.inst_pc), 64'(m_pc));
                chk("inst_data", bus.inst_data, exp_inst(m_pc));
            end
            if (bus.redirect_valid) begin
                m_t  = 1;
                m_pc = bus.redirect_pc;
            end else if (exp_valid && bus.inst_ready) begin
                m_t  = 1;
                m_pc = m_pc + 32'd8;
            end else if (m_t < 10) begin
                m_t++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.inst_valid && n < 40) begin
            step();
            n++;
        end
        chk("valid_seen", 64'(bus.inst_valid), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [15:0] wrap_seq [8];

        wrap_seq = '{16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF,
                     16'h0000, 16'h0001, 16'h0002, 16'h0003};
        for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
        ram[0] = 8'h01; ram[1] = 8'h00; ram[2] = 8'h02; ram[3] = 8'h03;
        ram[4] = 8'h00; ram[5] = 8'h00; ram[6] = 8'h00; ram[7] = 8'h05;

        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;

        // Reset release, first instruction, 20-cycle stall.
        step();
        step();
        rst_n = 1'b1;
        wait_valid(n);
        chk("first_valid_cycle", 64'(n), 64'd10);
        chk("first_data", bus.inst_data, 64'h0100020300000005);
        chk("first_pc", 64'(bus.inst_pc), 64'd0);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("stall_re", 64'(bus.mem_re), 64'd0);
            chk("stall_data", bus.inst_data, 64'h0100020300000005);
            chk("stall_pc", 64'(bus.inst_pc), 64'd0);
        end
        bus.inst_ready = 1'b1;
        step();
        chk("after_xfer_valid", 64'(bus.inst_valid), 64'd0);
        chk("after_xfer_addr", 64'(bus.mem_addr), 64'h8);

        // Redirect after 4 bytes issued.
        repeat (4) step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        step();
        bus.redirect_valid = 1'b0;
        chk("redir_addr", 64'(bus.mem_addr), 64'h40);
        wait_valid(n);
        chk("redir_latency", 64'(n), 64'd9);
        chk("redir_pc", 64'(bus.inst_pc), 64'h40);
        chk("redir_data", bus.inst_data, exp_inst(32'h40));

        // Redirect and transfer in the same cycle.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        step();
        bus.redirect_valid = 1'b0;
        chk("rx_valid", 64'(bus.inst_valid), 64'd0);
        chk("rx_addr", 64'(bus.mem_addr), 64'h100);
        wait_valid(n);
        chk("rx_pc", 64'(bus.inst_pc), 64'h100);

        // Address wrap within one instruction.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_FFFC;
        step();
        bus.redirect_valid = 1'b0;
        bus.inst_ready     = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("wrap_addr", 64'(bus.mem_addr), 64'(wrap_seq[i]));
            step();
        end
        wait_valid(n);
        chk("wrap_pc", 64'(bus.inst_pc), 64'h0000_FFFC);

        // Asynchronous reset while holding.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 64'(bus.inst_valid), 64'd0);
        chk("async_data", bus.inst_data, 64'd0);
        step();
        step();
        rst_n = 1'b1;
        bus.inst_ready = 1'b1;
        wait_valid(n);
        chk("refetch_cycle", 64'(n), 64'd10);
        chk("refetch_pc", 64'(bus.inst_pc), 64'(RST_PC));

        // Random ready/redirect traffic.
        for (int i = 0; i < 3000; i++) begin
            step();
            bus.inst_ready     = 1'($urandom_range(0, 1));
            bus.redirect_valid = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0)
                bus.redirect_pc = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
            else
                bus.redirect_pc = $urandom;
        end
        step();
        bus.redirect_valid = 1'b0;
        repeat (30) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
